xz_scrub_fifo: RTL

- Parametrised 4-state hygiene stage for multi-channel buses driven by resolved or multi-driven nets.
- Accepts CH channels of W bits each through a valid/ready handshake.
- For each accepted beat it detects X/Z bits per channel, replaces them according to a selectable mode, and buffers the scrubbed beat in a DEPTH-entry FIFO.
- Keeps saturating per-channel X/Z event counters. It sits between multi-driver interconnect and 2-state consumers.

---
 rtl/xz_scrub_fifo.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/xz_scrub_fifo.sv
// ============================================================================
// xz_scrub_fifo : 4-state hygiene stage that detects and scrubs X/Z bits per
//                 channel, buffers scrubbed beats in a FIFO, and counts events.
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module xz_scrub_fifo #(
  parameter int CH    = 4,
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic                       clr_cnt,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CH*W-1:0]            in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CH*W-1:0]            out_data,
  output logic [CH-1:0]              out_xz,
  output logic [CH*CNT_W-1:0]        xz_cnt,
  output logic                       err_sticky,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CH*W-1:0]  r_mem_data [DEPTH];
  logic [CH-1:0]    r_mem_xz   [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [W-1:0]     r_last_clean [CH];
  logic [CNT_W-1:0] r_cnt [CH];
  logic             r_err;

  logic [CH*W-1:0]  w_bit_xz;
  logic [CH*W-1:0]  w_scrub;
  logic [CH-1:0]    w_chan_xz;
  logic             w_push;
  logic             w_pop;

  assign in_ready   = (r_level < LW'(DEPTH));
  assign out_valid  = (r_level != '0);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;
  assign out_data   = r_mem_data[r_rd_ptr];
  assign out_xz     = r_mem_xz[r_rd_ptr];
  assign level      = r_level;
  assign err_sticky = r_err;

  // Case equality is the only operator that sees X and Z as distinct values.
  generate
    for (genvar i = 0; i < CH*W; i++) begin : g_det
      assign w_bit_xz[i] = !((in_data[i] === 1'b0) || (in_data[i] === 1'b1));
    end
    for (genvar c = 0; c < CH; c++) begin : g_cnt
      assign xz_cnt[c*CNT_W +: CNT_W] = r_cnt[c];
    end
  endgenerate

  always_comb begin
    w_chan_xz = '0;
    w_scrub   = in_data;
    for (int c = 0; c < CH; c++) begin
      for (int b = 0; b < W; b++) begin
        if (w_bit_xz[c*W + b]) begin
          w_chan_xz[c] = 1'b1;
          case (mode)
            2'd0:    w_scrub[c*W + b] = 1'b0;
            2'd1:    w_scrub[c*W + b] = 1'b1;
            2'd2:    w_scrub[c*W + b] = r_last_clean[c][b];
            default: w_scrub[c*W + b] = in_data[c*W + b];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_xz[i]   <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= w_scrub;
        r_mem_xz[r_wr_ptr]   <= w_chan_xz;
        r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Pass-through mode leaves the hold-last history untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        r_last_clean[c] <= '0;
        r_cnt[c]        <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (w_push && (mode != 2'd3)) begin
          r_last_clean[c] <= w_scrub[c*W +: W];
        end
        if (clr_cnt) begin
          r_cnt[c] <= '0;
        end else if (w_push && w_chan_xz[c] && (r_cnt[c] != '1)) begin
          r_cnt[c] <= r_cnt[c] + CNT_W'(1);
        end
      end
      if (clr_cnt) begin
        r_err <= 1'b0;
      end else if (w_push && (w_chan_xz != '0)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
